// File: rtl/parking_meter_pkg.sv
// Shared definitions for the parking meter codebase: button FSM encoding and
// default hold/repeat timing constants.
package parking_meter_pkg;

  // Button event FSM state, 2-bit encoding
  typedef enum logic [1:0] {
    StLockout = 2'd0,
    StIdle    = 2'd1,
    StPressed = 2'd2,
    StHold    = 2'd3
  } btn_state_e;

  // Default timing in clk cycles
  localparam int unsigned DefLongCycles   = 50000000;
  localparam int unsigned DefRepeatCycles = 10000000;

endpackage

// File: rtl/btn_event.sv
// Button event generator: turns a debounced button level into press, release,
// long-press and auto-repeat pulses plus a held level. All outputs registered.
// 'release' and 'repeat' are reserved words, so those pulses are exposed as
// btn_release and btn_repeat.
module btn_event
  import parking_meter_pkg::*;
#(
  parameter int unsigned CNT_W         = 26,
  parameter int unsigned LONG_CYCLES   = DefLongCycles,
  parameter int unsigned REPEAT_CYCLES = DefRepeatCycles
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_level,
  output logic press,
  output logic btn_release,
  output logic long_press,
  output logic btn_repeat,
  output logic held
);

  // Reject timing that the counter cannot represent or that is degenerate
  if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2 ||
      64'(LONG_CYCLES) > (64'd1 << CNT_W) ||
      64'(REPEAT_CYCLES) > (64'd1 << CNT_W)) begin : g_param_err
    $error("btn_event: LONG_CYCLES/REPEAT_CYCLES must be >= 2 and <= 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] LongMax   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] RepeatMax = CNT_W'(REPEAT_CYCLES - 1);

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             press_d, release_d, long_d, repeat_d, held_d;

  // Next-state, counter and pulse decode; release wins over any threshold
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    unique case (state_q)
      // Wait for the button to be seen released before accepting a press
      StLockout: begin
        count_d = '0;
        if (!btn_level) state_d = StIdle;
      end
      StIdle: begin
        count_d = '0;
        if (btn_level) begin
          state_d = StPressed;
          press_d = 1'b1;
        end
      end
      StPressed: begin
        if (!btn_level) begin
          state_d   = StIdle;
          count_d   = '0;
          release_d = 1'b1;
        end else if (count_q == LongMax) begin
          state_d = StHold;
          count_d = '0;
          long_d  = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      StHold: begin
        if (!btn_level) begin
          state_d   = StIdle;
          count_d   = '0;
          release_d = 1'b1;
        end else if (count_q == RepeatMax) begin
          count_d  = '0;
          repeat_d = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StLockout;
        count_d = '0;
      end
    endcase

    held_d = (state_d == StPressed) || (state_d == StHold);
  end

  // State, counter and registered outputs; reset parks in lockout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StLockout;
      count_q     <= '0;
      press       <= 1'b0;
      btn_release <= 1'b0;
      long_press  <= 1'b0;
      btn_repeat  <= 1'b0;
      held        <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      press       <= press_d;
      btn_release <= release_d;
      long_press  <= long_d;
      btn_repeat  <= repeat_d;
      held        <= held_d;
    end
  end

endmodule
